fifo_word_packer: RTL and testbench

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_word_packer.sv | 117 +++++++++++
 tb/tb_fifo_word_packer.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and counter sizing helper for the FIFO word packer.
package fifo_pkg;

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned DefaultPack      = 4;

    // Counters must be able to hold the value PACK itself, not just PACK-1.
    function automatic int unsigned cnt_width(input int unsigned pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Gathers PACK bytes from a one-cycle-latency FIFO into one little-endian output word.
// Defining PACKER_PARITY_EN adds a registered even-parity output (out_parity).
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned PACK       = DefaultPack
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic                       fifo_empty,
    input  logic [DATA_WIDTH-1:0]      fifo_dout,
    output logic                       fifo_rd_en,
    output logic [DATA_WIDTH*PACK-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready
`ifdef PACKER_PARITY_EN
    ,
    output logic                       out_parity
`endif
);

    localparam int unsigned     CntW    = cnt_width(PACK);
    localparam int unsigned     WordW   = DATA_WIDTH * PACK;
    localparam logic [CntW-1:0] PackCnt = CntW'(PACK);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [CntW-1:0]  req_cnt_q, req_cnt_d;
    logic [CntW-1:0]  cap_cnt_q, cap_cnt_d;
    logic             pending_q, pending_d;
    logic [WordW-1:0] asm_q, asm_d;
    logic [WordW-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             load;

    always_comb begin
        fifo_rd_en  = rst_ && !fifo_empty && (req_cnt_q < PackCnt);
        load        = (cap_cnt_q == PackCnt) && (!out_valid_q || out_ready);

        req_cnt_d   = req_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        pending_d   = fifo_rd_en;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (fifo_rd_en) begin
            req_cnt_d = req_cnt_q + CntOne;
        end

        // Byte requested last cycle is on fifo_dout now; drop it into its lane.
        if (pending_q) begin
            for (int unsigned i = 0; i < PACK; i++) begin
                if (cap_cnt_q == CntW'(i)) begin
                    asm_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
                end
            end
            cap_cnt_d = cap_cnt_q + CntOne;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A full word implies every request was captured, so no read or capture
        // can coincide with the load.
        if (load) begin
            out_data_d  = asm_q;
            out_valid_d = 1'b1;
            req_cnt_d   = '0;
            cap_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            req_cnt_q   <= '0;
            cap_cnt_q   <= '0;
            pending_q   <= 1'b0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            req_cnt_q   <= req_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            pending_q   <= pending_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef PACKER_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (load) begin
            parity_d = ^asm_q;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: FIFO model, scoreboard and randomized traffic.
// Parity checks are included when PACKER_PARITY_EN is defined.
module tb_fifo_word_packer;

    localparam int unsigned DW = 8;
    localparam int unsigned PK = 4;
    localparam int unsigned WW = DW * PK;

    logic          clk         = 1'b0;
    logic          rst_        = 1'b0;
    logic          force_empty = 1'b0;
    logic          out_ready   = 1'b0;
    logic [7:0]    mem [0:255];
    logic [7:0]    wr_ptr      = 8'd0;
    logic [7:0]    rd_ptr      = 8'd0;
    logic [DW-1:0] fifo_dout   = '0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          out_valid;
    logic [WW-1:0] out_data;
    logic          out_par;

    int errors       = 0;
    int checks       = 0;
    int rd_pulses    = 0;
    int valid_cycles = 0;
    int viol         = 0;
    int got_cnt      = 0;
    logic [WW-1:0] got_data [0:63];
    logic          got_par  [0:63];

    always #5 clk = ~clk;

    assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

    fifo_word_packer #(
        .DATA_WIDTH (DW),
        .PACK       (PK)
    ) dut (
        .clk        (clk),
        .rst_       (rst_),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef PACKER_PARITY_EN
        ,
        .out_parity (out_par)
`endif
    );

`ifndef PACKER_PARITY_EN
    assign out_par = 1'b0;
`endif

    // Upstream FIFO with one-cycle read latency plus output scoreboard capture.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
            rd_pulses <= rd_pulses + 1;
        end
        if (fifo_rd_en && (fifo_empty || !rst_)) viol <= viol + 1;
        if (rst_ && out_valid) valid_cycles <= valid_cycles + 1;
        if (rst_ && out_valid && out_ready) begin
            got_data[got_cnt[5:0]] <= out_data;
            got_par[got_cnt[5:0]]  <= out_par;
            got_cnt                <= got_cnt + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    function automatic logic [WW-1:0] model_word(input logic [7:0] bytes[$], input int base);
        logic [WW-1:0] w = '0;
        for (int i = 0; i < int'(PK); i++) begin
            w = w | (WW'(bytes[base + i]) << (DW * i));
        end
        return w;
    endfunction

    task automatic wait_words(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (got_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            errors++; $display("FAIL reset_data: got %h want 0", out_data);
        end
`ifdef PACKER_PARITY_EN
        checks++;
        if (out_par !== 1'b0) begin
            errors++; $display("FAIL reset_parity: got %b want 0", out_par);
        end
`endif
        rst_ = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: valid=%b rd_en=%b want 0 0", out_valid, fifo_rd_en);
        end
    endtask

    task automatic test_basic();
        int rd0 = rd_pulses;
        int v0  = valid_cycles;
        int g0  = got_cnt;
        bit ok;
        out_ready = 1'b1;
        @(negedge clk);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_words(g0 + 1, 50, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL basic_timeout: got %0d words want %0d", got_cnt - g0, 1);
        end
        checks++;
        if (got_data[g0[5:0]] !== 32'h04030201) begin
            errors++; $display("FAIL basic_word: got %h want 04030201", got_data[g0[5:0]]);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rd_pulses - rd0 != 4) begin
            errors++; $display("FAIL basic_rd_pulses: got %0d want 4", rd_pulses - rd0);
        end
        checks++;
        if (valid_cycles - v0 != 1) begin
            errors++; $display("FAIL basic_valid_cycles: got %0d want 1", valid_cycles - v0);
        end
`ifdef PACKER_PARITY_EN
        checks++;
        if (got_par[g0[5:0]] !== 1'b1) begin
            errors++; $display("FAIL parity_04030201: got %b want 1", got_par[g0[5:0]]);
        end
`endif
    endtask

    task automatic test_backpressure();
        int rd0 = rd_pulses;
        int g0  = got_cnt;
        logic [7:0] bytes[$];
        bit ok;
        out_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            bytes.push_back(8'(8'h10 + i));
            push(8'(8'h10 + i));
        end
        repeat (14) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h13121110) begin
            errors++;
            $display("FAIL bp_hold: valid=%b data=%h want 1 13121110", out_valid, out_data);
        end
        checks++;
        if (rd_pulses - rd0 != 8) begin
            errors++; $display("FAIL bp_rd_stall: got %0d reads want 8", rd_pulses - rd0);
        end
        checks++;
        if (fifo_rd_en !== 1'b0 || fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL bp_rd_en: rd_en=%b empty=%b want 0 0", fifo_rd_en, fifo_empty);
        end
        out_ready = 1'b1;
        wait_words(g0 + 3, 80, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL bp_timeout: got %0d words want 3", got_cnt - g0);
        end
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (got_data[6'(g0 + w)] !== model_word(bytes, w * int'(PK))) begin
                errors++;
                $display("FAIL bp_word%0d: got %h want %h", w, got_data[6'(g0 + w)],
                         model_word(bytes, w * int'(PK)));
            end
        end
    endtask

    task automatic test_gap();
        int g0 = got_cnt;
        bit ok;
        out_ready = 1'b1;
        @(negedge clk);
        push(8'hAA); push(8'hBB);
        repeat (7) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || got_cnt != g0) begin
            errors++;
            $display("FAIL gap_partial: valid=%b words=%0d want 0 0", out_valid, got_cnt - g0);
        end
        push(8'hCC); push(8'hDD);
        wait_words(g0 + 1, 50, ok);
        repeat (4) @(negedge clk);
        checks++;
        if (!ok || got_cnt != g0 + 1) begin
            errors++; $display("FAIL gap_count: got %0d words want 1", got_cnt - g0);
        end
        checks++;
        if (got_data[g0[5:0]] !== 32'hDDCCBBAA) begin
            errors++; $display("FAIL gap_word: got %h want ddccbbaa", got_data[g0[5:0]]);
        end
    endtask

    task automatic test_reset_midword();
        int g0 = got_cnt;
        bit ok;
        out_ready = 1'b1;
        @(negedge clk);
        push(8'hE1); push(8'hE2);
        repeat (4) @(negedge clk);
        rst_ = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_clear: valid=%b data=%h want 0 0", out_valid, out_data);
        end
        push(8'h05); push(8'h06); push(8'h07); push(8'h08);
        @(negedge clk);
        checks++;
        if (fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en);
        end
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        wait_words(g0 + 1, 50, ok);
        repeat (6) @(negedge clk);
        checks++;
        if (!ok || got_cnt != g0 + 1) begin
            errors++; $display("FAIL rst_count: got %0d words want 1", got_cnt - g0);
        end
        checks++;
        if (got_data[g0[5:0]] !== 32'h08070605) begin
            errors++; $display("FAIL rst_word: got %h want 08070605", got_data[g0[5:0]]);
        end
    endtask

`ifdef PACKER_PARITY_EN
    task automatic test_parity();
        int g0 = got_cnt;
        bit ok;
        out_ready = 1'b1;
        @(negedge clk);
        push(8'h00); push(8'h00); push(8'h03); push(8'h03);
        wait_words(g0 + 1, 50, ok);
        checks++;
        if (!ok || got_data[g0[5:0]] !== 32'h03030000) begin
            errors++; $display("FAIL parity_word: got %h want 03030000", got_data[g0[5:0]]);
        end
        checks++;
        if (got_par[g0[5:0]] !== 1'b0) begin
            errors++; $display("FAIL parity_03030000: got %b want 0", got_par[g0[5:0]]);
        end
    endtask
`endif

    task automatic test_random();
        int            g0     = got_cnt;
        int            nwords = 12;
        logic [7:0]    bytes[$];
        bit            stall_prev = 1'b0;
        logic [WW-1:0] prev_data  = '0;
        bit            done       = 1'b0;
        @(negedge clk);
        for (int i = 0; i < nwords * int'(PK); i++) begin
            bytes.push_back(8'($urandom_range(0, 255)));
            push(bytes[i]);
        end
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL rand_hold: valid=%b data=%h want 1 %h",
                             out_valid, out_data, prev_data);
                end
            end
            if (got_cnt >= g0 + nwords) begin
                done = 1'b1;
                break;
            end
            force_empty = ($urandom_range(0, 3) == 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            stall_prev  = out_valid && !out_ready;
            prev_data   = out_data;
        end
        force_empty = 1'b0;
        out_ready   = 1'b1;
        checks++;
        if (!done) begin
            errors++; $display("FAIL rand_timeout: got %0d words want %0d", got_cnt - g0, nwords);
        end
        for (int w = 0; w < nwords; w++) begin
            checks++;
            if (got_data[6'(g0 + w)] !== model_word(bytes, w * int'(PK))) begin
                errors++;
                $display("FAIL rand_word%0d: got %h want %h", w, got_data[6'(g0 + w)],
                         model_word(bytes, w * int'(PK)));
            end
`ifdef PACKER_PARITY_EN
            checks++;
            if (got_par[6'(g0 + w)] !== ^model_word(bytes, w * int'(PK))) begin
                errors++;
                $display("FAIL rand_parity%0d: got %b want %b", w, got_par[6'(g0 + w)],
                         ^model_word(bytes, w * int'(PK)));
            end
`endif
        end
    endtask

    task automatic test_no_rd_when_empty();
        repeat (3) @(negedge clk);
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL rd_en_while_empty: got %0d events want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gap();
        test_reset_midword();
`ifdef PACKER_PARITY_EN
        test_parity();
`endif
        test_random();
        test_no_rd_when_empty();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
